instr_fetch_unit: RTL and testbench

Instruction-fetch initiator for the RISC core. It owns the program counter and drives the address port of the instruction block memory, which has one cycle of synchronous read latency. It captures the returned words into a 2-entry queue and presents them to decode over a valid/ready handshake. Jump and branch redirects flush all fetched and in-flight instructions.

---
 rtl/risc_pkg.sv | 30 +++
 rtl/instr_fetch_unit_if.sv | 30 +++
 rtl/fetch_queue.sv | 72 +++++++
 rtl/instr_fetch_unit.sv | 108 ++++++++++
 tb/tb_instr_fetch_unit.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/risc_pkg.sv
// Shared definitions for the RISC core: instruction width, fetch FSM
// state encoding and opcode field constants used by decode.
package risc_pkg;

   localparam int INSTR_W = 32;

   // Opcode field position inside an instruction word
   localparam int OPC_HI = 31;
   localparam int OPC_LO = 26;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } fetch_state_t;

   // Opcode values (bits 31:26) reserved for decode
   localparam logic [5:0] OPC_ALU    = 6'b000000;
   localparam logic [5:0] OPC_ALUI   = 6'b000001;
   localparam logic [5:0] OPC_LOAD   = 6'b000010;
   localparam logic [5:0] OPC_STORE  = 6'b000011;
   localparam logic [5:0] OPC_BRANCH = 6'b000100;
   localparam logic [5:0] OPC_JUMP   = 6'b000101;

   // Extract the opcode field from an instruction word
   function automatic logic [5:0] opcode_of(input logic [INSTR_W-1:0] ins);
      return ins[OPC_HI:OPC_LO];
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of the fetch unit's memory port, decode handshake and redirect
// request. The master side is the fetch unit; the slave side is the
// surrounding memory/decode/branch logic.
interface instr_fetch_unit_if #(
   parameter int ADDR_W  = 3,
   parameter int INSTR_W = risc_pkg::INSTR_W
);
   logic                fetch_en;
   logic [ADDR_W-1:0]   mem_addr;
   logic                mem_we;
   logic [INSTR_W-1:0]  mem_din;
   logic [INSTR_W-1:0]  mem_dout;
   logic [INSTR_W-1:0]  instr;
   logic [ADDR_W-1:0]   instr_pc;
   logic                instr_valid;
   logic                instr_ready;
   logic                redirect_valid;
   logic [ADDR_W-1:0]   redirect_pc;

   modport master (
      input  fetch_en, mem_dout, instr_ready, redirect_valid, redirect_pc,
      output mem_addr, mem_we, mem_din, instr, instr_pc, instr_valid
   );

   modport slave (
      output fetch_en, mem_dout, instr_ready, redirect_valid, redirect_pc,
      input  mem_addr, mem_we, mem_din, instr, instr_pc, instr_valid
   );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO holding {instr, pc} pairs between the
// instruction memory and decode. Entry 0 is always the head, so the head
// outputs come straight from registers. flush wins over push and pop.
module fetch_queue
   import risc_pkg::*;
#(
   parameter int ADDR_W  = 3,
   parameter int INSTR_W = risc_pkg::INSTR_W
) (
   input  logic                clka,
   input  logic                rst,
   input  logic                push,
   input  logic [INSTR_W-1:0]  push_instr,
   input  logic [ADDR_W-1:0]   push_pc,
   input  logic                pop,
   input  logic                flush,
   output logic [1:0]          count,
   output logic [INSTR_W-1:0]  head_instr,
   output logic [ADDR_W-1:0]   head_pc
);

   logic [INSTR_W-1:0] instr0_r, instr1_r;
   logic [ADDR_W-1:0]  pc0_r, pc1_r;
   logic [1:0]         count_r;
   logic               pop_ok_s;
   logic               push_ok_s;
   logic [1:0]         wr_idx_s;

   // Qualify pop/push and find the slot a pushed entry lands in after any pop
   always_comb begin
      pop_ok_s  = pop && (count_r != 2'd0);
      wr_idx_s  = count_r - {1'b0, pop_ok_s};
      push_ok_s = push && (wr_idx_s != 2'd2);
   end

   // Storage and occupancy update: shift on pop, write at the free slot on push
   always_ff @(posedge clka) begin
      if (rst || flush) begin
         count_r  <= 2'd0;
         instr0_r <= {INSTR_W{1'b0}};
         instr1_r <= {INSTR_W{1'b0}};
         pc0_r    <= {ADDR_W{1'b0}};
         pc1_r    <= {ADDR_W{1'b0}};
      end else begin
         if (pop_ok_s) begin
            instr0_r <= instr1_r;
            pc0_r    <= pc1_r;
         end
         if (push_ok_s) begin
            case (wr_idx_s)
               2'd0: begin
                  instr0_r <= push_instr;
                  pc0_r    <= push_pc;
               end
               2'd1: begin
                  instr1_r <= push_instr;
                  pc1_r    <= push_pc;
               end
               default: begin
                  instr1_r <= instr1_r;
               end
            endcase
         end
         count_r <= count_r + {1'b0, push_ok_s} - {1'b0, pop_ok_s};
      end
   end

   assign count      = count_r;
   assign head_instr = instr0_r;
   assign head_pc    = pc0_r;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch initiator. Owns the PC, drives the instruction memory
// address (one cycle read latency), lands returned words in a 2-entry
// queue and hands them to decode over valid/ready. A redirect reloads the
// PC and throws away everything fetched or still in flight.
module instr_fetch_unit
   import risc_pkg::*;
#(
   parameter int                ADDR_W   = 3,
   parameter int                INSTR_W  = risc_pkg::INSTR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
   input  logic                 clka,
   input  logic                 rst,
   instr_fetch_unit_if.master   bus
);

   fetch_state_t        state_r;
   logic [ADDR_W-1:0]   pc_r;
   logic [ADDR_W-1:0]   inflight_pc_r;
   logic                inflight_r;

   logic [1:0]          count_s;
   logic [INSTR_W-1:0]  head_instr_s;
   logic [ADDR_W-1:0]   head_pc_s;
   logic                valid_s;
   logic                pop_s;
   logic                push_s;
   logic                issue_s;
   logic [2:0]          occ_s;

   // Handshake, push and issue decisions for the current cycle
   always_comb begin
      valid_s = (count_s != 2'd0) && !bus.redirect_valid;
      pop_s   = valid_s && bus.instr_ready;
      // Occupancy the queue would have if this cycle issued nothing more
      occ_s   = {1'b0, count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
      issue_s = (state_r == S_RUN) && !bus.redirect_valid && (occ_s < 3'd2);
      // The returning word is dropped in a redirect cycle and while flushing
      push_s  = inflight_r && (state_r != S_FLUSH) && !bus.redirect_valid;
   end

   // FSM, program counter and in-flight tracking
   always_ff @(posedge clka) begin
      if (rst) begin
         state_r       <= S_IDLE;
         pc_r          <= RESET_PC;
         inflight_r    <= 1'b0;
         inflight_pc_r <= {ADDR_W{1'b0}};
      end else begin
         inflight_r <= issue_s;
         if (issue_s) begin
            inflight_pc_r <= pc_r;
         end
         if (bus.redirect_valid) begin
            pc_r <= bus.redirect_pc;
            if (inflight_r || (state_r == S_FLUSH)) begin
               state_r <= S_FLUSH;
            end else if (state_r == S_IDLE) begin
               state_r <= S_IDLE;
            end else begin
               state_r <= bus.fetch_en ? S_RUN : S_IDLE;
            end
         end else begin
            if (issue_s) begin
               pc_r <= pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
            case (state_r)
               S_IDLE: begin
                  state_r <= bus.fetch_en ? S_RUN : S_IDLE;
               end
               S_RUN: begin
                  state_r <= bus.fetch_en ? S_RUN : S_IDLE;
               end
               S_FLUSH: begin
                  state_r <= bus.fetch_en ? S_RUN : S_IDLE;
               end
               default: begin
                  state_r <= S_IDLE;
               end
            endcase
         end
      end
   end

   fetch_queue #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W)
   ) u_queue (
      .clka       (clka),
      .rst        (rst),
      .push       (push_s),
      .push_instr (bus.mem_dout),
      .push_pc    (inflight_pc_r),
      .pop        (pop_s),
      .flush      (bus.redirect_valid),
      .count      (count_s),
      .head_instr (head_instr_s),
      .head_pc    (head_pc_s)
   );

   assign bus.mem_addr    = pc_r;
   assign bus.mem_we      = 1'b0;
   assign bus.mem_din     = {INSTR_W{1'b0}};
   assign bus.instr       = head_instr_s;
   assign bus.instr_pc    = head_pc_s;
   assign bus.instr_valid = valid_s;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a vector table for the basic
// streaming/wrap behaviour plus hand-written stall, redirect and reset
// sequences. Each step drives inputs just after a rising edge and checks
// the outputs at the following falling edge, i.e. the view during that cycle.
module tb_instr_fetch_unit;

   localparam int AW = 3;
   localparam int IW = 32;

   logic clka;
   logic rst;
   int   n_checks;
   int   n_pass;
   logic [IW-1:0] mem [0:7];

   instr_fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

   instr_fetch_unit #(
      .ADDR_W   (AW),
      .INSTR_W  (IW),
      .RESET_PC (3'd0)
   ) dut (
      .clka (clka),
      .rst  (rst),
      .bus  (bus)
   );

   initial begin
      clka = 1'b0;
      forever #5 clka = ~clka;
   end

   // Synchronous-read instruction memory, one cycle latency
   always @(posedge clka) begin
      bus.mem_dout <= mem[bus.mem_addr];
   end

   typedef struct packed {
      logic          fe;
      logic          rdy;
      logic          ev;
      logic          cd;
      logic [IW-1:0] ei;
      logic [AW-1:0] ep;
      logic [AW-1:0] ea;
   } vec_t;

   vec_t tbl [14];

   function automatic logic [IW-1:0] w(input int i);
      return 32'hC0DE_0000 + (32'(i) * 32'h0000_0101);
   endfunction

   function automatic vec_t mk(input logic fe, input logic rdy, input logic ev,
                               input logic cd, input logic [IW-1:0] ei,
                               input logic [AW-1:0] ep, input logic [AW-1:0] ea);
      vec_t v;
      v.fe = fe; v.rdy = rdy; v.ev = ev; v.cd = cd;
      v.ei = ei; v.ep = ep; v.ea = ea;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock cycle: apply inputs, check outputs mid-cycle, move past the edge
   task automatic run_cycle(input string tag, input logic r, input logic fe,
                            input logic rdy, input logic rv, input logic [AW-1:0] rpc,
                            input logic ev, input logic [IW-1:0] ei,
                            input logic [AW-1:0] ep, input logic [AW-1:0] ea,
                            input logic cd);
      rst                = r;
      bus.fetch_en       = fe;
      bus.instr_ready    = rdy;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      @(negedge clka);
      check({tag, " instr_valid"}, {31'd0, bus.instr_valid}, {31'd0, ev});
      check({tag, " mem_addr"}, {29'd0, bus.mem_addr}, {29'd0, ea});
      if (cd) begin
         check({tag, " instr"}, bus.instr, ei);
         check({tag, " instr_pc"}, {29'd0, bus.instr_pc}, {29'd0, ep});
      end
      @(posedge clka);
      #1;
   endtask

   task automatic do_reset();
      rst                = 1'b1;
      bus.fetch_en       = 1'b0;
      bus.instr_ready    = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 3'd0;
      repeat (2) @(posedge clka);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      for (int i = 0; i < 8; i++) begin
         mem[i] = w(i);
      end

      // Stream from reset with ready held high, across the 7->0 wrap
      tbl[0]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 3'd0, 3'd0);
      tbl[1]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 3'd0, 3'd0);
      tbl[2]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 3'd0, 3'd0);
      tbl[3]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 3'd0, 3'd1);
      tbl[4]  = mk(1'b1, 1'b1, 1'b1, 1'b1, w(0),  3'd0, 3'd2);
      tbl[5]  = mk(1'b1, 1'b1, 1'b1, 1'b1, w(1),  3'd1, 3'd3);
      tbl[6]  = mk(1'b1, 1'b1, 1'b1, 1'b1, w(2),  3'd2, 3'd4);
      tbl[7]  = mk(1'b1, 1'b1, 1'b1, 1'b1, w(3),  3'd3, 3'd5);
      tbl[8]  = mk(1'b1, 1'b1, 1'b1, 1'b1, w(4),  3'd4, 3'd6);
      tbl[9]  = mk(1'b1, 1'b1, 1'b1, 1'b1, w(5),  3'd5, 3'd7);
      tbl[10] = mk(1'b1, 1'b1, 1'b1, 1'b1, w(6),  3'd6, 3'd0);
      tbl[11] = mk(1'b1, 1'b1, 1'b1, 1'b1, w(7),  3'd7, 3'd1);
      tbl[12] = mk(1'b1, 1'b1, 1'b1, 1'b1, w(0),  3'd0, 3'd2);
      tbl[13] = mk(1'b1, 1'b1, 1'b1, 1'b1, w(1),  3'd1, 3'd3);

      do_reset();
      check("reset mem_we", {31'd0, bus.mem_we}, 32'd0);
      check("reset mem_din", bus.mem_din, 32'd0);
      for (int i = 0; i < 14; i++) begin
         run_cycle($sformatf("T%0d", i), 1'b0, tbl[i].fe, tbl[i].rdy, 1'b0, 3'd0,
                   tbl[i].ev, tbl[i].ei, tbl[i].ep, tbl[i].ea, tbl[i].cd);
      end

      // A: decode stalls for 10 cycles, queue fills to 2, then drains back-to-back
      do_reset();
      run_cycle("A1", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 32'd0, 3'd0, 3'd0, 1'b0);
      run_cycle("A2", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 32'd0, 3'd0, 3'd0, 1'b0);
      run_cycle("A3", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 32'd0, 3'd0, 3'd1, 1'b0);
      for (int k = 0; k < 10; k++) begin
         run_cycle($sformatf("A stall%0d", k), 1'b0, 1'b1, 1'b0, 1'b0, 3'd0,
                   1'b1, w(0), 3'd0, 3'd2, 1'b1);
      end
      run_cycle("A14", 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, w(0), 3'd0, 3'd2, 1'b1);
      run_cycle("A15", 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, w(1), 3'd1, 3'd3, 1'b1);
      run_cycle("A16", 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, w(2), 3'd2, 3'd4, 1'b1);
      run_cycle("A17", 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, w(3), 3'd3, 3'd5, 1'b1);

      // B: redirect while a word is in flight, then two back-to-back redirects
      do_reset();
      run_cycle("B1", 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0, 3'd0, 3'd0, 1'b0);
      run_cycle("B2", 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0, 3'd0, 3'd0, 1'b0);
      run_cycle("B3", 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0, 3'd0, 3'd1, 1'b0);
      run_cycle("B4", 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, w(0), 3'd0, 3'd2, 1'b1);
      run_cycle("B5", 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, w(1), 3'd1, 3'd3, 1'b1);
      run_cycle("B6 redir5", 1'b0, 1'b1, 1'b1, 1'b1, 3'd5, 1'b0, 32'd0, 3'd0, 3'd4, 1'b0);
      run_cycle("B7 flush", 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0, 3'd0, 3'd5, 1'b0);
      run_cycle("B8", 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0, 3'd0, 3'd5, 1'b0);
      run_cycle("B9", 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0, 3'd0, 3'd6, 1'b0);
      run_cycle("B10", 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, w(5), 3'd5, 3'd7, 1'b1);
      run_cycle("B11", 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, w(6), 3'd6, 3'd0, 1'b1);
      run_cycle("B12 redir3", 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 32'd0, 3'd0, 3'd1, 1'b0);
      run_cycle("B13 redir6", 1'b0, 1'b1, 1'b1, 1'b1, 3'd6, 1'b0, 32'd0, 3'd0, 3'd3, 1'b0);
      run_cycle("B14 flush", 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0, 3'd0, 3'd6, 1'b0);
      run_cycle("B15", 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0, 3'd0, 3'd6, 1'b0);
      run_cycle("B16", 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0, 3'd0, 3'd7, 1'b0);
      run_cycle("B17", 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, w(6), 3'd6, 3'd0, 1'b1);
      run_cycle("B18", 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, w(7), 3'd7, 3'd1, 1'b1);
      run_cycle("B19", 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, w(0), 3'd0, 3'd2, 1'b1);

      // C: redirect with a full queue and nothing in flight, then reset mid-stream
      do_reset();
      run_cycle("C1", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 32'd0, 3'd0, 3'd0, 1'b0);
      run_cycle("C2", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 32'd0, 3'd0, 3'd0, 1'b0);
      run_cycle("C3", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 32'd0, 3'd0, 3'd1, 1'b0);
      run_cycle("C4", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, w(0), 3'd0, 3'd2, 1'b1);
      run_cycle("C5", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, w(0), 3'd0, 3'd2, 1'b1);
      run_cycle("C6 redir1", 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 32'd0, 3'd0, 3'd2, 1'b0);
      run_cycle("C7", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 32'd0, 3'd0, 3'd1, 1'b0);
      run_cycle("C8", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 32'd0, 3'd0, 3'd2, 1'b0);
      run_cycle("C9", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, w(1), 3'd1, 3'd3, 1'b1);
      run_cycle("C10", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, w(1), 3'd1, 3'd3, 1'b1);
      run_cycle("C11 rst", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, w(1), 3'd1, 3'd3, 1'b1);
      run_cycle("C12 post-rst", 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0, 3'd0, 3'd0, 1'b1);
      run_cycle("C13", 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0, 3'd0, 3'd0, 1'b0);
      run_cycle("C14", 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0, 3'd0, 3'd0, 1'b0);
      run_cycle("C15", 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0, 3'd0, 3'd1, 1'b0);
      run_cycle("C16", 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, w(0), 3'd0, 3'd2, 1'b1);
      run_cycle("C17", 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, w(1), 3'd1, 3'd3, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
